// File: rtl/bch_pkg.sv
// rtl/bch_pkg.sv - BCH(31,26) code constants and decoder state encoding
package bch_pkg;
  localparam int N = 31;
  localparam int K = 26;
  localparam int M = 5;
  localparam logic [4:0] G_LOW = 5'b00101;
  localparam logic [4:0] MATCH = 5'b10010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYND,
    ST_CORR,
    ST_DONE
  } state_t;
endpackage

// File: rtl/bch_lfsr5.sv
// rtl/bch_lfsr5.sv - 5-bit shifter computing s <= s*x + din mod g
module bch_lfsr5
  import bch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic         din,
  output logic [M-1:0] s
);

  logic [M-1:0] r_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s <= '0;
    end else if (clr) begin
      r_s <= '0;
    end else if (en) begin
      r_s <= {r_s[M-2:0], din} ^ (r_s[M-1] ? G_LOW : 5'b00000);
    end
  end

  assign s = r_s;

endmodule

// File: rtl/bch_meggitt_dec.sv
// rtl/bch_meggitt_dec.sv - single-error Meggitt decoder for BCH(31,26), g = x^5+x^2+1
module bch_meggitt_dec
  import bch_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_code,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [K-1:0]  out_data,
  output logic          out_corrected,
  output logic [4:0]    out_err_pos,
  output logic          busy
);

  state_t       r_state;
  logic [N-1:0] r_buf;
  logic [4:0]   r_cnt;
  logic [K-1:0] r_out_data;
  logic         r_corrected;
  logic [4:0]   r_err_pos;
  logic         r_out_valid;

  logic [M-1:0] w_s;
  logic         w_accept;
  logic         w_match;
  logic         w_last;

  assign w_accept = (r_state == ST_IDLE) && in_valid;
  assign w_match  = (r_state == ST_CORR) && (w_s == MATCH);
  assign w_last   = (r_cnt == 5'd30);

  // Buffer rotates left in both passes, so bit 30 is always the bit under test
  // and 31 rotations restore the original order.
  bch_lfsr5 u_lfsr (
    .clk (clk),
    .rst (rst),
    .clr (w_accept || w_match),
    .en  ((r_state == ST_SYND) || (r_state == ST_CORR)),
    .din ((r_state == ST_SYND) ? r_buf[N-1] : 1'b0),
    .s   (w_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_buf       <= '0;
      r_cnt       <= '0;
      r_out_data  <= '0;
      r_corrected <= 1'b0;
      r_err_pos   <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_buf       <= in_code;
            r_cnt       <= '0;
            r_corrected <= 1'b0;
            r_err_pos   <= '0;
            r_state     <= ST_SYND;
          end
        end
        ST_SYND: begin
          r_buf <= {r_buf[N-2:0], r_buf[N-1]};
          r_cnt <= w_last ? 5'd0 : r_cnt + 5'd1;
          if (w_last) r_state <= ST_CORR;
        end
        ST_CORR: begin
          r_buf <= {r_buf[N-2:0], r_buf[N-1] ^ w_match};
          if (w_match) begin
            r_corrected <= 1'b1;
            r_err_pos   <= 5'd30 - r_cnt;
          end
          r_cnt <= w_last ? 5'd0 : r_cnt + 5'd1;
          if (w_last) r_state <= ST_DONE;
        end
        ST_DONE: begin
          // First DONE cycle publishes the data word; it then holds until accepted.
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_out_data  <= r_buf[N-1:M];
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready      = (r_state == ST_IDLE);
  assign busy          = (r_state == ST_SYND) || (r_state == ST_CORR);
  assign out_valid     = r_out_valid;
  assign out_data      = r_out_data;
  assign out_corrected = r_corrected;
  assign out_err_pos   = r_err_pos;

endmodule

// File: tb/tb_bch_meggitt_dec.sv
// tb/tb_bch_meggitt_dec.sv - randomized and directed checks of bch_meggitt_dec against a brute-force nearest-codeword model
module tb_bch_meggitt_dec;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [30:0] in_code = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [25:0] out_data;
  logic        out_corrected;
  logic [4:0]  out_err_pos;
  logic        busy;

  int total = 0;
  int bad = 0;

  bch_meggitt_dec dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_corrected(out_corrected), .out_err_pos(out_err_pos),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Long division of the word by g(x) = x^5 + x^2 + 1 (0x25).
  function automatic logic [4:0] poly_rem(input logic [30:0] v);
    logic [30:0] t;
    t = v;
    for (int i = 30; i >= 5; i--)
      if (t[i]) t = t ^ (31'h25 << (i - 5));
    return t[4:0];
  endfunction

  function automatic logic [30:0] encode(input logic [25:0] m);
    logic [30:0] c;
    c = {m, 5'b00000};
    return c | {26'd0, poly_rem(c)};
  endfunction

  // Nearest codeword by trying every single flip: {corrected, pos[4:0], data[25:0]}.
  function automatic logic [31:0] ref_dec(input logic [30:0] r);
    logic [30:0] f;
    if (poly_rem(r) == 5'd0) return {1'b0, 5'd0, r[30:5]};
    for (int j = 0; j < 31; j++) begin
      f = r ^ (31'd1 << j);
      if (poly_rem(f) == 5'd0) return {1'b1, j[4:0], f[30:5]};
    end
    return 32'hFFFF_FFFF;
  endfunction

  task automatic send(input logic [30:0] code);
    int k;
    k = 0;
    while (!in_ready && k < 200) begin @(posedge clk); #1; k++; end
    chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    in_code  = code;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_code  = 31'($urandom);
  endtask

  task automatic wait_out();
    int k;
    k = 0;
    while (!out_valid && k < 100) begin @(posedge clk); #1; k++; end
    chk("latency", k, 63);
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("in_ready_after_take", {31'd0, in_ready}, 32'd1);
    chk("valid_after_take", {31'd0, out_valid}, 32'd0);
  endtask

  task automatic check_out(input string tag, input logic [30:0] code);
    logic [31:0] e;
    e = ref_dec(code);
    chk({tag, "_data"}, {6'd0, out_data}, {6'd0, e[25:0]});
    chk({tag, "_corr"}, {31'd0, out_corrected}, {31'd0, e[31]});
    chk({tag, "_pos"}, {27'd0, out_err_pos}, {27'd0, e[30:26]});
  endtask

  task automatic decode(input string tag, input logic [30:0] code);
    send(code);
    wait_out();
    check_out(tag, code);
    take();
  endtask

  initial begin
    logic [25:0] d;
    logic [30:0] a, b;
    logic [25:0] hold_data;
    logic        hold_corr;
    logic [4:0]  hold_pos;
    logic        stable, saw_ready, saw_valid;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_out_data", {6'd0, out_data}, 32'd0);
    chk("rst_corr", {31'd0, out_corrected}, 32'd0);
    chk("rst_pos", {27'd0, out_err_pos}, 32'd0);

    send(31'h0000_0000);
    chk("busy_synd", {31'd0, busy}, 32'd1);
    chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
    wait_out();
    chk("zero_data", {6'd0, out_data}, 32'd0);
    chk("zero_corr", {31'd0, out_corrected}, 32'd0);
    chk("zero_pos", {27'd0, out_err_pos}, 32'd0);
    take();

    decode("bit0", 31'h0000_0001);
    chk("bit0_pos_direct", {27'd0, out_err_pos}, 32'd0);
    decode("bit30", 31'h4000_0000);
    chk("bit30_pos_direct", {27'd0, out_err_pos}, 32'd30);
    decode("ones", 31'h7FFF_FFFF);
    chk("ones_data_direct", {6'd0, out_data}, 32'h03FF_FFFF);
    decode("ones_b5", 31'h7FFF_FFDF);
    chk("ones_b5_pos_direct", {27'd0, out_err_pos}, 32'd5);

    for (int p = 0; p < 31; p++) begin
      d = 26'($urandom);
      a = encode(d) ^ (31'd1 << p);
      send(a);
      wait_out();
      chk("sweep_data", {6'd0, out_data}, {6'd0, d});
      chk("sweep_pos", {27'd0, out_err_pos}, p);
      chk("sweep_corr", {31'd0, out_corrected}, 32'd1);
      take();
    end

    for (int n = 0; n < 6; n++) decode("rand", 31'($urandom));
    decode("clean", encode(26'($urandom)));

    a = encode(26'($urandom)) ^ 31'h0000_0400;
    b = 31'($urandom);
    send(a);
    wait_out();
    hold_data = out_data; hold_corr = out_corrected; hold_pos = out_err_pos;
    in_code = b; in_valid = 1'b1;
    stable = 1'b1; saw_ready = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (!out_valid || out_data !== hold_data || out_corrected !== hold_corr ||
          out_err_pos !== hold_pos) stable = 1'b0;
      if (in_ready) saw_ready = 1'b1;
    end
    chk("hold_stable", {31'd0, stable}, 32'd1);
    chk("hold_no_ready", {31'd0, saw_ready}, 32'd0);
    check_out("hold", a);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("next_accepted", {31'd0, busy}, 32'd1);
    wait_out();
    check_out("after_hold", b);
    take();

    a = encode(26'($urandom)) ^ 31'h0010_0000;
    send(a);
    saw_valid = 1'b0;
    repeat (39) begin @(posedge clk); #1; if (out_valid) saw_valid = 1'b1; end
    chk("busy_in_corr", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #2;
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (80) begin @(posedge clk); #1; if (out_valid) saw_valid = 1'b1; end
    chk("abort_no_valid", {31'd0, saw_valid}, 32'd0);
    chk("abort_idle_ready", {31'd0, in_ready}, 32'd1);
    decode("post_abort", encode(26'($urandom)) ^ 31'h0000_0008);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
